// File: rtl/id_regfile_sb.sv
// ID-stage integer register file with per-register busy scoreboard.
// Combinational read ports, one WB write port, optional WB->ID write-through bypass.
module id_regfile_sb #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned BYPASS = 1,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic [NUM_RD*AW-1:0]     i_rdReg,
   output logic [NUM_RD*XLEN-1:0]   o_rdData,
   output logic [NUM_RD-1:0]        o_rdBusy,
   input  logic                     en_WB,
   input  logic                     i_wrSig,
   input  logic [AW-1:0]            i_wrReg,
   input  logic [XLEN-1:0]          i_wrData,
   input  logic                     i_rsvSig,
   input  logic [AW-1:0]            i_rsvReg,
   output logic                     o_rsvReady,
   input  logic                     i_flush,
   output logic [AW:0]              o_busyCnt
);

   localparam int unsigned CW  = AW + 1;
   localparam bit          BYP = (BYPASS != 0);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [CW-1:0]    busy_cnt_q, busy_cnt_d;

   logic wr, rsv, wr_clears;

   assign wr         = en_WB & i_wrSig & (i_wrReg != '0);
   assign o_rsvReady = (i_rsvReg == '0) | ~busy_q[i_rsvReg];
   assign rsv        = i_rsvSig & o_rsvReady & (i_rsvReg != '0) & ~i_flush;
   // A same-reg reserve can only be accepted when the reg is idle, so it never masks a clear.
   assign wr_clears  = wr & busy_q[i_wrReg];

   for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;
      assign addr = i_rdReg[k*AW +: AW];
      assign hit  = BYP & wr & (i_wrReg == addr);
      assign o_rdData[k*XLEN +: XLEN] = (addr == '0) ? '0 :
                                        hit          ? i_wrData : regs_q[addr];
      assign o_rdBusy[k] = busy_q[addr] & ~hit;
   end

   // Flush beats WB clear, reserve set beats WB clear on the same register.
   always_comb begin
      busy_d     = busy_q;
      busy_cnt_d = busy_cnt_q;
      if (i_flush) begin
         busy_d     = '0;
         busy_cnt_d = '0;
      end else begin
         if (wr)  busy_d[i_wrReg]  = 1'b0;
         if (rsv) busy_d[i_rsvReg] = 1'b1;
         busy_cnt_d = busy_cnt_q + CW'(rsv) - CW'(wr_clears);
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         if (wr) regs_q[i_wrReg] <= i_wrData;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign o_busyCnt = busy_cnt_q;

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb; a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_id_regfile_sb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  rd_reg;
   logic        en_wb, wr_sig, rsv_sig, flush;
   logic [4:0]  wr_reg, rsv_reg;
   logic [31:0] wr_data;

   logic [63:0] rd_data,  rd_data_nb;
   logic [1:0]  rd_busy,  rd_busy_nb;
   logic        rsv_rdy,  rsv_rdy_nb;
   logic [5:0]  cnt,      cnt_nb;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_regfile_sb #(.BYPASS(1)) u_dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_rdReg(rd_reg), .o_rdData(rd_data),
      .o_rdBusy(rd_busy), .en_WB(en_wb), .i_wrSig(wr_sig), .i_wrReg(wr_reg),
      .i_wrData(wr_data), .i_rsvSig(rsv_sig), .i_rsvReg(rsv_reg),
      .o_rsvReady(rsv_rdy), .i_flush(flush), .o_busyCnt(cnt));

   id_regfile_sb #(.BYPASS(0)) u_dut_nb (
      .i_clk(clk), .i_reset_n(reset_n), .i_rdReg(rd_reg), .o_rdData(rd_data_nb),
      .o_rdBusy(rd_busy_nb), .en_WB(en_wb), .i_wrSig(wr_sig), .i_wrReg(wr_reg),
      .i_wrData(wr_data), .i_rsvSig(rsv_sig), .i_rsvReg(rsv_reg),
      .o_rsvReady(rsv_rdy_nb), .i_flush(flush), .o_busyCnt(cnt_nb));

   task automatic idle();
      en_wb = 0; wr_sig = 0; wr_reg = '0; wr_data = '0;
      rsv_sig = 0; rsv_reg = '0; flush = 0;
   endtask

   task automatic reserve(input logic [4:0] r);
      @(negedge clk); idle(); rsv_sig = 1; rsv_reg = r;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 0; idle(); rd_reg = {5'd5, 5'd3};
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
         failures++; $display("FAIL reset_read got=%h/%b exp=0/00", rd_data, rd_busy);
      end
      checks++;
      if (cnt !== 6'd0 || rsv_rdy !== 1'b1) begin
         failures++; $display("FAIL reset_cnt got=%0d rdy=%b exp=0 rdy=1", cnt, rsv_rdy);
      end
      @(negedge clk); reset_n = 1;
   endtask

   task automatic test_write_read();
      @(negedge clk); idle(); en_wb = 1; wr_sig = 1; wr_reg = 5'd5; wr_data = 32'hDEADBEEF;
      rd_reg = {5'd0, 5'd0};
      @(negedge clk); idle(); rd_reg = {5'd5, 5'd5}; #1;
      checks++;
      if (rd_data !== {2{32'hDEADBEEF}} || rd_data_nb !== {2{32'hDEADBEEF}}) begin
         failures++; $display("FAIL wr_x5 got=%h nb=%h exp=deadbeef x2", rd_data, rd_data_nb);
      end
      @(negedge clk); en_wb = 1; wr_sig = 1; wr_reg = 5'd0; wr_data = 32'h1234;
      rd_reg = {5'd5, 5'd0}; #1;
      checks++;
      if (rd_data !== {32'hDEADBEEF, 32'h0}) begin
         failures++; $display("FAIL wr_x0_bypass got=%h exp=deadbeef00000000", rd_data);
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (rd_data[31:0] !== 32'h0 || rd_data_nb[31:0] !== 32'h0) begin
         failures++; $display("FAIL wr_x0 got=%h nb=%h exp=0", rd_data[31:0], rd_data_nb[31:0]);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk); idle(); wr_sig = 1; wr_reg = 5'd7; wr_data = 32'h55; rd_reg = {5'd7, 5'd7};
      @(negedge clk); #1;
      checks++;
      if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
         failures++; $display("FAIL en_wb_low got=%h nb=%h exp=0", rd_data, rd_data_nb);
      end
      en_wb = 1; #1;
      checks++;
      if (rd_data !== {2{32'h55}}) begin
         failures++; $display("FAIL bypass_same_cycle got=%h exp=55 x2", rd_data);
      end
      checks++;
      if (rd_data_nb !== 64'h0) begin
         failures++; $display("FAIL nobypass_same_cycle got=%h exp=0", rd_data_nb);
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (rd_data_nb !== {2{32'h55}} || rd_data !== {2{32'h55}}) begin
         failures++; $display("FAIL x7_after got=%h nb=%h exp=55 x2", rd_data, rd_data_nb);
      end
   endtask

   task automatic test_scoreboard();
      @(negedge clk); idle(); rsv_sig = 1; rsv_reg = 5'd3; rd_reg = {5'd7, 5'd3}; #1;
      checks++;
      if (rsv_rdy !== 1'b1 || rd_busy !== 2'b00) begin
         failures++; $display("FAIL rsv_x3_pre got=rdy%b busy%b exp=rdy1 busy00", rsv_rdy, rd_busy);
      end
      @(negedge clk); #1;
      checks++;
      if (rd_busy !== 2'b01 || cnt !== 6'd1 || rsv_rdy !== 1'b0) begin
         failures++; $display("FAIL rsv_x3 got=busy%b cnt%0d rdy%b exp=busy01 cnt1 rdy0", rd_busy, cnt, rsv_rdy);
      end
      @(posedge clk); #1;
      checks++;
      if (cnt !== 6'd1) begin
         failures++; $display("FAIL rsv_x3_again got=%0d exp=1", cnt);
      end
      @(negedge clk); idle(); en_wb = 1; wr_sig = 1; wr_reg = 5'd3; wr_data = 32'hA;
      rd_reg = {5'd3, 5'd3}; #1;
      checks++;
      if (rd_busy !== 2'b00 || rd_busy_nb !== 2'b11) begin
         failures++; $display("FAIL wb_x3_busy got=%b nb=%b exp=00 nb=11", rd_busy, rd_busy_nb);
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (cnt !== 6'd0 || rd_busy_nb !== 2'b00 || rd_data_nb !== {2{32'hA}}) begin
         failures++; $display("FAIL wb_x3_done got=cnt%0d busy%b data%h exp=cnt0 busy00 data a x2", cnt, rd_busy_nb, rd_data_nb);
      end
   endtask

   task automatic test_waw();
      reserve(5'd4);
      @(negedge clk); idle(); rsv_sig = 1; rsv_reg = 5'd4; en_wb = 1; wr_sig = 1;
      wr_reg = 5'd4; wr_data = 32'h44; rd_reg = {5'd4, 5'd4}; #1;
      checks++;
      if (rsv_rdy !== 1'b0 || cnt !== 6'd1) begin
         failures++; $display("FAIL waw_refused got=rdy%b cnt%0d exp=rdy0 cnt1", rsv_rdy, cnt);
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (cnt !== 6'd0 || rd_busy !== 2'b00 || rd_data !== {2{32'h44}}) begin
         failures++; $display("FAIL waw_commit got=cnt%0d busy%b data%h exp=cnt0 busy00 44", cnt, rd_busy, rd_data);
      end
      rsv_sig = 1; rsv_reg = 5'd4; en_wb = 1; wr_sig = 1; wr_reg = 5'd4; wr_data = 32'h45; #1;
      checks++;
      if (rsv_rdy !== 1'b1) begin
         failures++; $display("FAIL rsv_wr_same_rdy got=%b exp=1", rsv_rdy);
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (cnt !== 6'd1 || rd_busy !== 2'b11 || rd_data !== {2{32'h45}}) begin
         failures++; $display("FAIL rsv_wr_same got=cnt%0d busy%b data%h exp=cnt1 busy11 45", cnt, rd_busy, rd_data);
      end
      en_wb = 1; wr_sig = 1; wr_reg = 5'd4; wr_data = 32'h46;
      @(negedge clk); idle(); #1;
      checks++;
      if (cnt !== 6'd0) begin
         failures++; $display("FAIL waw_cleanup got=%0d exp=0", cnt);
      end
   endtask

   task automatic test_flush();
      reserve(5'd1); reserve(5'd2); reserve(5'd9);
      checks++;
      if (cnt !== 6'd3 || cnt_nb !== 6'd3) begin
         failures++; $display("FAIL three_rsv got=%0d nb=%0d exp=3", cnt, cnt_nb);
      end
      // reserve one reg while retiring another: count unchanged
      @(negedge clk); idle(); rsv_sig = 1; rsv_reg = 5'd11; en_wb = 1; wr_sig = 1;
      wr_reg = 5'd1; wr_data = 32'h11;
      @(posedge clk); #1;
      checks++;
      if (cnt !== 6'd3) begin
         failures++; $display("FAIL back_to_back got=%0d exp=3", cnt);
      end
      // write to a non-busy reg must not decrement
      @(negedge clk); idle(); en_wb = 1; wr_sig = 1; wr_reg = 5'd20; wr_data = 32'h20;
      @(posedge clk); #1;
      checks++;
      if (cnt !== 6'd3) begin
         failures++; $display("FAIL wr_nonbusy got=%0d exp=3", cnt);
      end
      @(negedge clk); idle(); flush = 1; rsv_sig = 1; rsv_reg = 5'd10; en_wb = 1; wr_sig = 1;
      wr_reg = 5'd9; wr_data = 32'h99; rd_reg = {5'd9, 5'd10};
      @(negedge clk); idle(); #1;
      checks++;
      if (cnt !== 6'd0 || rd_busy !== 2'b00 || rd_data[63:32] !== 32'h99) begin
         failures++; $display("FAIL flush got=cnt%0d busy%b x9=%h exp=cnt0 busy00 x9=99", cnt, rd_busy, rd_data[63:32]);
      end
      rd_reg = {5'd2, 5'd11}; #1;
      checks++;
      if (rd_busy !== 2'b00 || rd_busy_nb !== 2'b00) begin
         failures++; $display("FAIL flush_others got=%b nb=%b exp=00", rd_busy, rd_busy_nb);
      end
   endtask

   task automatic test_async_reset();
      reserve(5'd5);
      @(negedge clk); idle(); rd_reg = {5'd5, 5'd3}; #1;
      checks++;
      if (rd_data !== {32'hDEADBEEF, 32'hA} || rd_busy !== 2'b10 || cnt !== 6'd1) begin
         failures++; $display("FAIL pre_reset got=%h busy%b cnt%0d exp=deadbeef0000000a busy10 cnt1", rd_data, rd_busy, cnt);
      end
      #1 reset_n = 0; #1;
      checks++;
      if (rd_data !== 64'h0 || rd_data_nb !== 64'h0 || rd_busy !== 2'b00 || cnt !== 6'd0) begin
         failures++; $display("FAIL async_reset got=%h nb=%h busy%b cnt%0d exp=0", rd_data, rd_data_nb, rd_busy, cnt);
      end
      @(negedge clk); reset_n = 1; rd_reg = {5'd7, 5'd5}; #1;
      checks++;
      if (rd_data !== 64'h0 || rsv_rdy !== 1'b1 || cnt_nb !== 6'd0) begin
         failures++; $display("FAIL post_reset got=%h rdy%b cnt%0d exp=0 rdy1 cnt0", rd_data, rsv_rdy, cnt_nb);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_waw();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
